// File: rtl/apb_pkg.sv
// apb_pkg: shared widths, timeout default and bridge state encoding for the APB bridge/slave pair
package apb_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} apb_state_t;
endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command, response and APB3 bus signals of the bridge; master = bridge side
interface apb_master_bridge_if import apb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: ACCESS wait counter; expired flags the wait cycle that reaches TIMEOUT_CYCLES
module apb_wait_timer import apb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) cnt <= 8'd0;
    else if (clr) cnt <= 8'd0;
    else if (inc) cnt <= cnt + 8'd1;
  assign expired = inc && cnt == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command to single-slave APB3 transfer, one outstanding at a time
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge import apb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic pclk,
  input logic presetn,
  apb_master_bridge_if.master bus
);
  apb_state_t state;
  logic expired;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 1..255");
  end
`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .pclk(pclk),
    .presetn(presetn),
    .clr(state == SETUP),
    .inc(state == ACCESS && !bus.pready),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  assign bus.cmd_ready = state == IDLE;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state <= IDLE;
      bus.psel <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite <= 1'b0;
      bus.paddr <= '0;
      bus.pwdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err <= 1'b0;
      bus.rsp_rdata <= '0;
    end else
      case (state)
        IDLE: if (bus.cmd_valid) begin
          bus.pwrite <= bus.cmd_write;
          bus.paddr <= bus.cmd_addr[ADDR_W-1:0];
          bus.pwdata <= bus.cmd_write ? bus.cmd_wdata : {DATA_W{1'b0}};
          bus.psel <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: if (bus.pready || expired) begin
          // pready wins over a timeout landing in the same cycle
          bus.rsp_rdata <= (bus.pwrite || !bus.pready) ? {DATA_W{1'b0}} : bus.prdata;
          bus.rsp_err <= bus.pready ? bus.pslverr : 1'b1;
          bus.psel <= 1'b0;
          bus.penable <= 1'b0;
          bus.rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench with a planned APB slave and a memory reference model
module tb_apb_master_bridge;
  localparam int TO = 16;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;
  apb_master_bridge_if #(.ADDR_W(4), .DATA_W(8)) bus();
  apb_master_bridge #(.ADDR_W(4), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk),
    .presetn(presetn),
    .bus(bus)
  );
  typedef struct {logic w; logic [3:0] a; logic [7:0] d; int waits; logic e;} plan_t;
  typedef struct {logic [7:0] rd; logic e;} rsp_t;
  plan_t plan_q[$];
  rsp_t exp_q[$];
  logic [7:0] mmem [16];
  logic [7:0] smem [16];
  int vecs = 0;
  int errs = 0;
  int rr_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  plan_t cur;
  int acnt = 0;
  bit have = 0;
  bit done_chk = 0;
  always @(negedge pclk) begin
    if (done_chk) begin
      chk("rsp_latency", bus.rsp_valid, 1);
      done_chk = 0;
    end
    if (bus.penable) chk("penable_without_psel", bus.psel, 1);
    if (bus.psel && !bus.penable) begin
      if (plan_q.size() == 0) chk("unplanned_setup", 0, 1);
      else begin
        cur = plan_q.pop_front();
        have = 1;
        acnt = 0;
        chk("setup_paddr", bus.paddr, cur.a);
        chk("setup_pwrite", bus.pwrite, cur.w);
        chk("setup_pwdata", bus.pwdata, cur.w ? cur.d : 8'h00);
      end
      bus.pready = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata = 8'($urandom);
    end else if (bus.psel && bus.penable && have) begin
      chk("access_paddr", bus.paddr, cur.a);
      chk("access_pwrite", bus.pwrite, cur.w);
      chk("access_pwdata", bus.pwdata, cur.w ? cur.d : 8'h00);
      if (acnt == cur.waits) begin
        bus.pready = 1'b1;
        bus.pslverr = cur.e;
        bus.prdata = smem[cur.a];
        if (cur.w && !cur.e) smem[cur.a] = cur.d;
        done_chk = 1;
        have = 0;
      end else begin
        bus.pready = 1'b0;
        bus.pslverr = 1'($urandom);
        bus.prdata = 8'($urandom);
      end
      acnt++;
    end else begin
      bus.pready = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata = 8'($urandom);
    end
  end

  bit hold = 0;
  logic [7:0] h_rd;
  logic h_e;
  rsp_t got;
  always @(negedge pclk) begin
    bus.rsp_ready = rr_mode == 0 ? 1'($urandom) : rr_mode == 1;
    if (hold) begin
      chk("rsp_hold_valid", bus.rsp_valid, 1);
      chk("rsp_hold_rdata", bus.rsp_rdata, h_rd);
      chk("rsp_hold_err", bus.rsp_err, h_e);
    end
    if (bus.rsp_valid) chk("cmd_ready_in_resp", bus.cmd_ready, 0);
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        got = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, got.rd);
        chk("rsp_err", bus.rsp_err, got.e);
      end
    end
    hold = bus.rsp_valid && !bus.rsp_ready;
    h_rd = bus.rsp_rdata;
    h_e = bus.rsp_err;
  end

  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d, input int waits,
                       input logic e, input bit expect_rsp);
    plan_t p;
    rsp_t r;
    bit to;
    int n;
    to = 0;
`ifdef APB_TIMEOUT_EN
    to = waits >= TO;
`endif
    p = '{w, a, d, waits, e};
    plan_q.push_back(p);
    if (expect_rsp) begin
      r.rd = (w || to) ? 8'h00 : mmem[a];
      r.e = to ? 1'b1 : e;
      if (w && !to && !e) mmem[a] = d;
      exp_q.push_back(r);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr = a;
    bus.cmd_wdata = d;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (!bus.cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(posedge pclk);
    @(negedge pclk);
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 500) begin
      @(negedge pclk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr = 4'h0;
    bus.cmd_wdata = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 8'($urandom);
      smem[i] = mmem[i];
    end
    rr_mode = 1;
    #1;
    chk("reset_psel", bus.psel, 0);
    chk("reset_penable", bus.penable, 0);
    chk("reset_pwrite", bus.pwrite, 0);
    chk("reset_paddr", bus.paddr, 0);
    chk("reset_pwdata", bus.pwdata, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    issue(1'b1, 4'h3, 8'hA5, 0, 1'b0, 1);
    chk("lat_setup_psel", bus.psel, 1);
    chk("lat_setup_penable", bus.penable, 0);
    @(negedge pclk);
    chk("lat_access_psel", bus.psel, 1);
    chk("lat_access_penable", bus.penable, 1);
    @(negedge pclk);
    chk("lat_rsp_valid", bus.rsp_valid, 1);
    chk("lat_resp_psel", bus.psel, 0);
    drain();
    chk("slave_mem3", smem[3], 8'hA5);
    issue(1'b0, 4'h3, 8'h5A, 0, 1'b0, 1);
    drain();
    issue(1'b0, 4'h3, 8'h00, 3, 1'b0, 1);
    drain();
    rr_mode = 2;
    issue(1'b0, 4'h7, 8'h00, 0, 1'b1, 1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge pclk);
      n++;
    end
    chk("err_rsp_seen", bus.rsp_valid, 1);
    repeat (5) begin
      @(negedge pclk);
      chk("err_hold_valid", bus.rsp_valid, 1);
      chk("err_hold_cmd_ready", bus.cmd_ready, 0);
    end
    rr_mode = 1;
    @(negedge pclk);
    @(negedge pclk);
    chk("post_hs_rsp_valid", bus.rsp_valid, 0);
    chk("post_hs_cmd_ready", bus.cmd_ready, 1);
    issue(1'b0, 4'h5, 8'h00, 10, 1'b0, 0);
    @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    chk("midrst_psel", bus.psel, 0);
    chk("midrst_penable", bus.penable, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (20) @(negedge pclk);
    chk("after_rst_rsp_valid", bus.rsp_valid, 0);
    chk("after_rst_cmd_ready", bus.cmd_ready, 1);
    issue(1'b1, 4'h9, 8'h3C, 1, 1'b0, 1);
    issue(1'b0, 4'h9, 8'h00, 0, 1'b0, 1);
    drain();
    rr_mode = 0;
`ifdef APB_TIMEOUT_EN
    issue(1'b0, 4'h2, 8'h00, 40, 1'b0, 1);
    issue(1'b1, 4'h2, 8'hC3, 40, 1'b0, 1);
    issue(1'b0, 4'h2, 8'h00, TO - 1, 1'b0, 1);
    drain();
`endif
    repeat (200) begin
      int w;
      w = $urandom_range(0, 4);
`ifdef APB_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) w = $urandom_range(TO - 3, TO + 4);
`endif
      issue(1'($urandom), 4'($urandom), 8'($urandom), w, $urandom_range(0, 3) == 0, 1);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
